// File: rtl/memory_bank_config_writer.sv
// rtl/memory_bank_config_writer.sv - BL/WL memory-bank row writer (setup, one-hot WL pulse, hold)
// Optional even-parity check on config words when CFG_PARITY_EN is defined.
module memory_bank_config_writer #(
  parameter int NUM_BL       = 6,
  parameter int NUM_WL       = 10,
  parameter int ADDR_WIDTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [NUM_BL-1:0]     cfg_data,
`ifdef CFG_PARITY_EN
  input  logic                  cfg_parity,
`endif
  output logic [NUM_BL-1:0]     bl,
  output logic [NUM_WL-1:0]     wl,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  cfg_err_clr,
  output logic [CNT_WIDTH-1:0]  rows_written
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_ERR} state_t;

  localparam int TMAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_BL-1:0]     data_q, data_d;
  logic [NUM_BL-1:0]     bl_q, bl_d;
  logic [NUM_WL-1:0]     wl_q, wl_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hs, addr_ok, par_ok;

  assign hs      = cfg_valid & ready_q & (state_q == S_IDLE);
  assign addr_ok = 32'(cfg_addr) < 32'(NUM_WL);
`ifdef CFG_PARITY_EN
  assign par_ok  = ~(^{cfg_addr, cfg_data, cfg_parity});
`else
  assign par_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          addr_d = cfg_addr;
          data_d = cfg_data;
          if (addr_ok && par_ok) begin
            state_d = S_SETUP;
            tmr_d   = TW'(SETUP_CYCLES - 1);
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_PULSE;
          tmr_d   = TW'(PULSE_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_PULSE: begin
        if (tmr_q == '0) state_d = S_HOLD;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_HOLD: begin
        state_d = S_IDLE;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Error set takes priority over a coincident clear.
    if (cfg_err_clr)        err_d = 1'b0;
    if (state_q == S_ERR)   err_d = 1'b1;

    // Outputs are registered from the current state, so they trail the state by one edge.
    bl_d    = (state_q inside {S_SETUP, S_PULSE, S_HOLD}) ? data_q : '0;
    wl_d    = (state_q == S_PULSE) ? (NUM_WL'(1) << addr_q) : '0;
    ready_d = (state_q == S_IDLE) && !hs;
    busy_d  = (state_q != S_IDLE);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bl           = bl_q;
  assign wl           = wl_q;
  assign cfg_ready    = ready_q;
  assign cfg_busy     = busy_q;
  assign cfg_err      = err_q;
  assign rows_written = cnt_q;

endmodule

// File: tb/tb_memory_bank_config_writer.sv
// tb/tb_memory_bank_config_writer.sv - directed bench for memory_bank_config_writer
module tb_memory_bank_config_writer;

  logic        prog_clk, prog_reset, cfg_valid, cfg_err_clr;
  logic [3:0]  cfg_addr;
  logic [5:0]  cfg_data;
  logic        cfg_parity;
  logic        cfg_ready, cfg_busy, cfg_err;
  logic [5:0]  bl;
  logic [9:0]  wl;
  logic [15:0] rows_written;
  logic        sat_ready, sat_busy, sat_err;
  logic [5:0]  sat_bl;
  logic [9:0]  sat_wl;
  logic [1:0]  sat_rows;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rw   = 0;
  logic exp_err = 1'b0;

  memory_bank_config_writer u_dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .bl(bl), .wl(wl), .cfg_busy(cfg_busy), .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr),
    .rows_written(rows_written)
  );

  memory_bank_config_writer #(.CNT_WIDTH(2)) u_sat (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_valid(cfg_valid), .cfg_ready(sat_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .bl(sat_bl), .wl(sat_wl), .cfg_busy(sat_busy), .cfg_err(sat_err), .cfg_err_clr(cfg_err_clr),
    .rows_written(sat_rows)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves cfg_valid high so a caller can chain words back-to-back.
  task automatic write_row(input logic [3:0] a, input logic [5:0] d, input logic par_good);
    logic       ok;
    logic [9:0] ewl;
    int         last;
    for (int n = 0; n < 20 && cfg_ready !== 1'b1; n++) tick();
    check("ready_idle", {31'd0, cfg_ready}, 1);
    cfg_valid  = 1'b1;
    cfg_addr   = a;
    cfg_data   = d;
    cfg_parity = (^{a, d}) ^ ~par_good;
    ok = par_good && (a < 4'd10);
    tick();
    check("ready_drop", {31'd0, cfg_ready}, 0);
    last = ok ? 5 : 2;
    for (int k = 1; k <= last; k++) begin
      tick();
      ewl = (ok && (k == 2 || k == 3)) ? (10'd1 << a) : 10'd0;
      check("bl", {26'd0, bl}, (ok && k <= 4) ? {26'd0, d} : 32'd0);
      check("wl", {22'd0, wl}, {22'd0, ewl});
      check("ready", {31'd0, cfg_ready}, (k == last) ? 32'd1 : 32'd0);
      check("busy", {31'd0, cfg_busy}, (ok ? (k <= 4) : (k == 1)) ? 32'd1 : 32'd0);
    end
    if (ok) exp_rw++;
    else    exp_err = 1'b1;
    check("rows", {16'd0, rows_written}, exp_rw);
    check("rows_sat", {30'd0, sat_rows}, (exp_rw > 3) ? 3 : exp_rw);
    check("err", {31'd0, cfg_err}, {31'd0, exp_err});
  endtask

  initial begin
    prog_reset  = 1'b1;
    cfg_valid   = 1'b0;
    cfg_err_clr = 1'b0;
    cfg_addr    = '0;
    cfg_data    = '0;
    cfg_parity  = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'd0, cfg_ready}, 0);
    check("rst_bl", {26'd0, bl}, 0);
    check("rst_wl", {22'd0, wl}, 0);
    check("rst_busy", {31'd0, cfg_busy}, 0);
    check("rst_err", {31'd0, cfg_err}, 0);
    check("rst_rows", {16'd0, rows_written}, 0);
    prog_reset = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, cfg_ready}, 1);

    // Abort a write of row 5 in the middle of its WL pulse.
    cfg_valid = 1'b1;
    cfg_addr  = 4'd5;
    cfg_data  = 6'b110011;
    cfg_parity = ^{4'd5, 6'b110011};
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    check("abort_wl_on", {22'd0, wl}, 32'b0000100000);
    check("abort_bl_on", {26'd0, bl}, 32'b110011);
    prog_reset = 1'b1;
    tick();
    check("abort_wl", {22'd0, wl}, 0);
    check("abort_bl", {26'd0, bl}, 0);
    check("abort_busy", {31'd0, cfg_busy}, 0);
    check("abort_rows", {16'd0, rows_written}, 0);
    prog_reset = 1'b0;
    tick();

    write_row(4'd3, 6'b101101, 1'b1);
    cfg_valid = 1'b0;

    write_row(4'd12, 6'h3F, 1'b1);
    cfg_valid = 1'b0;
    repeat (3) tick();
    check("oor_err_sticky", {31'd0, cfg_err}, 1);
    check("oor_wl", {22'd0, wl}, 0);
    check("oor_bl", {26'd0, bl}, 0);
    check("oor_rows", {16'd0, rows_written}, 1);
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_clr", {31'd0, cfg_err}, 0);

    for (int i = 0; i < 10; i++) write_row(4'(i), 6'(i * 5 + 1), 1'b1);
    cfg_valid = 1'b0;
    check("b2b_rows", {16'd0, rows_written}, 11);
    check("sat_rows", {30'd0, sat_rows}, 3);

`ifdef CFG_PARITY_EN
    write_row(4'd1, 6'b000001, 1'b0);
    cfg_valid = 1'b0;
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    exp_err = 1'b0;
    check("par_err_clr", {31'd0, cfg_err}, 0);
    write_row(4'd1, 6'b000001, 1'b1);
    cfg_valid = 1'b0;
    check("par_rows", {16'd0, rows_written}, 12);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
